cache_refill_ctrl: RTL and testbench

- Miss-handling engine that sits between the cache pipeline and the memory bridge, and drives the write port of the cache way storage.
- On a miss it writes back a dirty victim line if needed, fetches the new line as 4×32-bit beats, and merges any pending store into it.
- It then issues one full-line write (`w_type=2'b10`) into the victim way and returns the requested word to the pipeline.

---
 rtl/cache_refill_ctrl_pkg.sv | 50 +++++
 rtl/cache_refill_ctrl_if.sv | 26 ++
 rtl/cache_line_merge.sv | 21 ++
 rtl/cache_refill_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache miss/refill engine: widths, line layouts,
// way-write encodings and controller states.
package cache_defs;

    localparam int CacheIndexWidth  = 8;
    localparam int CacheOffsetWidth = 4;
    localparam int CacheTagWidth    = 20;
    localparam int WordW            = 32;
    localparam int AddrW            = 32;
    localparam int LineDataW        = 128;
    localparam int LineW            = 150;

    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_PART = 2'b01,
        W_FULL = 2'b10
    } w_type_e;

    // Read-side layout {d, v, tag, data}
    localparam int RdDirtyBit = 149;
    localparam int RdValidBit = 148;
    localparam int RdTagMsb   = 147;
    localparam int RdTagLsb   = 128;
    localparam int RdDataMsb  = 127;
    localparam int RdDataLsb  = 0;

    // Write-side layout {v, tag, data, d}
    localparam int WrValidBit = 149;
    localparam int WrTagMsb   = 148;
    localparam int WrTagLsb   = 129;
    localparam int WrDataMsb  = 128;
    localparam int WrDataLsb  = 1;
    localparam int WrDirtyBit = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB_REQ = 3'd1,
        S_RD_REQ = 3'd2,
        S_RECV   = 3'd3,
        S_REFILL = 3'd4
    } state_e;

    function automatic logic [AddrW-1:0] line_addr(
        input logic [CacheTagWidth-1:0]   tag,
        input logic [CacheIndexWidth-1:0] index
    );
        return {tag, index, {CacheOffsetWidth{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Memory-bridge side of the refill engine: writeback, line fetch and return beats.
interface cache_refill_ctrl_if;
    import cache_defs::*;

    logic                 wr_req_o;
    logic [AddrW-1:0]     wr_addr_o;
    logic [LineDataW-1:0] wr_data_o;
    logic                 wr_rdy_i;
    logic                 rd_req_o;
    logic [AddrW-1:0]     rd_addr_o;
    logic                 rd_rdy_i;
    logic                 ret_valid_i;
    logic                 ret_last_i;
    logic [WordW-1:0]     ret_data_i;

    modport master (
        output wr_req_o, wr_addr_o, wr_data_o, rd_req_o, rd_addr_o,
        input  wr_rdy_i, rd_rdy_i, ret_valid_i, ret_last_i, ret_data_i
    );

    modport slave (
        input  wr_req_o, wr_addr_o, wr_data_o, rd_req_o, rd_addr_o,
        output wr_rdy_i, rd_rdy_i, ret_valid_i, ret_last_i, ret_data_i
    );

endinterface

// File: rtl/cache_line_merge.sv
// Combinational store merge: overlays enabled bytes of a word into one word of a line.
module cache_line_merge
    import cache_defs::*;
(
    input  logic [LineDataW-1:0] line,
    input  logic [1:0]           word_sel,
    input  logic [3:0]           wstrb,
    input  logic [WordW-1:0]     wdata,
    output logic [LineDataW-1:0] merged
);

    always_comb begin
        merged = line;
        for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) begin
                merged[{word_sel, 5'b00000} + 7'(k * 8) +: 8] = wdata[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine: optional dirty writeback, 4-beat line fetch, store merge,
// then a single full-line write into the victim way plus the requested word.
module cache_refill_ctrl
    import cache_defs::*;
#(
    parameter int WAYS    = 2,
    parameter int INDEX_W = CacheIndexWidth,
    parameter int TAG_W   = 20
) (
    input  logic                                    clk,
    input  logic                                    rst_n,

    input  logic                                    miss_valid_i,
    output logic                                    miss_ready_o,
    input  logic [INDEX_W-1:0]                      miss_index_i,
    input  logic [TAG_W-1:0]                        miss_tag_i,
    input  logic [3:0]                              miss_offset_i,
    input  logic                                    miss_op_i,
    input  logic [3:0]                              miss_wstrb_i,
    input  logic [WordW-1:0]                        miss_wdata_i,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] victim_way_i,
    input  logic [LineW-1:0]                        victim_line_i,

    cache_refill_ctrl_if.master                     bus,

    output logic [WAYS-1:0]                         way_req_o,
    output logic [INDEX_W-1:0]                      way_w_index_o,
    output logic [1:0]                              way_w_type_o,
    output logic [3:0]                              way_offset_o,
    output logic [3:0]                              way_wstrb_o,
    output logic [LineW-1:0]                        way_w_data_o,
    output logic                                    done_o,
    output logic [WordW-1:0]                        done_rdata_o
);

    localparam int WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e state_q, state_d;
    logic   [1:0] cnt_q;

    logic [INDEX_W-1:0]   idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic [3:0]           off_q;
    logic                 op_q;
    logic [3:0]           wstrb_q;
    logic [WordW-1:0]     wdata_q;
    logic [WayW-1:0]      way_q;
    logic [TAG_W-1:0]     vtag_q;
    logic [LineDataW-1:0] vdata_q;
    logic [WordW-1:0]     beat_q [4];

    logic                 accept;
    logic                 victim_dirty;
    logic [LineDataW-1:0] fill_line;
    logic [LineDataW-1:0] merged;
    logic [LineW-1:0]     w_line;

    assign accept       = miss_valid_i && (state_q == S_IDLE);
    assign victim_dirty = victim_line_i[RdValidBit] && victim_line_i[RdDirtyBit];
    assign fill_line    = {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};

    cache_line_merge u_merge (
        .line     (fill_line),
        .word_sel (off_q[3:2]),
        .wstrb    (op_q ? wstrb_q : 4'b0000),
        .wdata    (wdata_q),
        .merged   (merged)
    );

    always_comb begin
        w_line                      = '0;
        w_line[WrValidBit]          = 1'b1;
        w_line[WrTagMsb:WrTagLsb]   = tag_q;
        w_line[WrDataMsb:WrDataLsb] = merged;
        w_line[WrDirtyBit]          = op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RD_REQ) begin
                cnt_q <= 2'd0;
            end else if (state_q == S_RECV && bus.ret_valid_i) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    // Request context and fill buffer carry no reset; outputs are gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= miss_index_i;
            tag_q   <= miss_tag_i;
            off_q   <= miss_offset_i;
            op_q    <= miss_op_i;
            wstrb_q <= miss_wstrb_i;
            wdata_q <= miss_wdata_i;
            way_q   <= victim_way_i;
            vtag_q  <= victim_line_i[RdTagMsb:RdTagLsb];
            vdata_q <= victim_line_i[RdDataMsb:RdDataLsb];
        end
        if (state_q == S_RECV && bus.ret_valid_i) begin
            beat_q[cnt_q] <= bus.ret_data_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_ready_o  = 1'b0;
        bus.wr_req_o  = 1'b0;
        bus.wr_addr_o = '0;
        bus.wr_data_o = '0;
        bus.rd_req_o  = 1'b0;
        bus.rd_addr_o = '0;
        way_req_o     = '0;
        way_w_index_o = '0;
        way_w_type_o  = W_NONE;
        way_offset_o  = '0;
        way_wstrb_o   = '0;
        way_w_data_o  = '0;
        done_o        = 1'b0;
        done_rdata_o  = '0;

        case (state_q)
            S_IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    state_d = victim_dirty ? S_WB_REQ : S_RD_REQ;
                end
            end
            S_WB_REQ: begin
                bus.wr_req_o  = 1'b1;
                bus.wr_addr_o = {vtag_q, idx_q, 4'h0};
                bus.wr_data_o = vdata_q;
                if (bus.wr_rdy_i) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                bus.rd_req_o  = 1'b1;
                bus.rd_addr_o = {tag_q, idx_q, 4'h0};
                if (bus.rd_rdy_i) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.ret_valid_i && bus.ret_last_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                for (int i = 0; i < WAYS; i++) begin
                    way_req_o[i] = (way_q == WayW'(i));
                end
                way_w_index_o = idx_q;
                way_w_type_o  = W_FULL;
                way_offset_o  = off_q;
                way_w_data_o  = w_line;
                done_o        = 1'b1;
                done_rdata_o  = merged[{off_q[3:2], 5'b00000} +: WordW];
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected bridge and
// way-write events; a negedge monitor pops and compares as the DUT presents them.
module tb_cache_refill_ctrl;
    import cache_defs::*;

    localparam int WAYS = 2;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [WAYS-1:0] way;
        logic [7:0]      idx;
        logic [149:0]    wd;
        logic [31:0]     rdata;
        logic [3:0]      off;
        int              lat;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          miss_valid;
    logic          miss_ready;
    logic [7:0]    miss_index;
    logic [19:0]   miss_tag;
    logic [3:0]    miss_offset;
    logic          miss_op;
    logic [3:0]    miss_wstrb;
    logic [31:0]   miss_wdata;
    logic [0:0]    victim_way;
    logic [149:0]  victim_line;
    logic [WAYS-1:0] way_req;
    logic [7:0]    way_w_index;
    logic [1:0]    way_w_type;
    logic [3:0]    way_offset;
    logic [3:0]    way_wstrb;
    logic [149:0]  way_w_data;
    logic          done;
    logic [31:0]   done_rdata;

    cache_refill_ctrl_if bus();

    cache_refill_ctrl #(.WAYS(WAYS), .INDEX_W(8), .TAG_W(20)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid_i  (miss_valid),
        .miss_ready_o  (miss_ready),
        .miss_index_i  (miss_index),
        .miss_tag_i    (miss_tag),
        .miss_offset_i (miss_offset),
        .miss_op_i     (miss_op),
        .miss_wstrb_i  (miss_wstrb),
        .miss_wdata_i  (miss_wdata),
        .victim_way_i  (victim_way),
        .victim_line_i (victim_line),
        .bus           (bus),
        .way_req_o     (way_req),
        .way_w_index_o (way_w_index),
        .way_w_type_o  (way_w_type),
        .way_offset_o  (way_offset),
        .way_wstrb_o   (way_wstrb),
        .way_w_data_o  (way_w_data),
        .done_o        (done),
        .done_rdata_o  (done_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = 0;

    wr_t         wr_q [$];
    logic [31:0] rd_q [$];
    done_t       done_q [$];

    task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Accept-cycle bookkeeping for latency: done in cycle acc+N means N cycles.
    always @(posedge clk) begin
        if (rst_n && miss_valid && miss_ready) acc = cyc;
        cyc = cyc + 1;
    end

    logic  wr_prev = 1'b0;
    logic  rd_prev = 1'b0;
    wr_t   cur_wr;
    logic [31:0] cur_rd;
    done_t e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_req_o) begin
                if (!wr_prev) begin
                    if (wr_q.size() == 0) chk("unexpected_wr_req", 1'b1, 1'b0);
                    else cur_wr = wr_q.pop_front();
                end
                chk("wr_addr", bus.wr_addr_o, cur_wr.addr);
                chk("wr_data", bus.wr_data_o, cur_wr.data);
            end
            wr_prev = bus.wr_req_o;
            if (bus.rd_req_o) begin
                if (!rd_prev) begin
                    if (rd_q.size() == 0) chk("unexpected_rd_req", 1'b1, 1'b0);
                    else cur_rd = rd_q.pop_front();
                end
                chk("rd_addr", bus.rd_addr_o, cur_rd);
            end
            rd_prev = bus.rd_req_o;
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = done_q.pop_front();
                    chk("way_req", way_req, e.way);
                    chk("way_w_index", way_w_index, e.idx);
                    chk("way_w_type", way_w_type, 2'b10);
                    chk("way_wstrb", way_wstrb, 4'b0000);
                    chk("way_offset", way_offset, e.off);
                    chk("way_w_data", way_w_data, e.wd);
                    chk("done_rdata", done_rdata, e.rdata);
                    if (e.lat >= 0) chk("latency", cyc - acc, e.lat);
                end
            end else begin
                chk("way_req_idle", {way_req, way_w_type}, '0);
            end
        end else begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    task automatic push_done(input logic [WAYS-1:0] way, input logic [7:0] idx,
                             input logic [149:0] wd, input logic [31:0] rdata,
                             input logic [3:0] off, input int lat);
        done_t d;
        d.way = way; d.idx = idx; d.wd = wd; d.rdata = rdata; d.off = off; d.lat = lat;
        done_q.push_back(d);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [127:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic issue(input logic [7:0] idx, input logic [19:0] tag, input logic [3:0] off,
                         input logic op, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic way, input logic [149:0] vline);
        int t = 0;
        while (!miss_ready && t < 50) begin @(negedge clk); t++; end
        chk("ready_before_issue", miss_ready, 1'b1);
        miss_index = idx; miss_tag = tag; miss_offset = off; miss_op = op;
        miss_wstrb = wstrb; miss_wdata = wdata; victim_way = way; victim_line = vline;
        miss_valid = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        victim_line = {150{1'b1}};
    endtask

    task automatic serve_wr(input int wait_n);
        int t = 0;
        while (!bus.wr_req_o && t < 20) begin @(negedge clk); t++; end
        chk("wr_req_seen", bus.wr_req_o, 1'b1);
        repeat (wait_n) @(negedge clk);
        bus.wr_rdy_i = 1'b1;
        @(negedge clk);
        bus.wr_rdy_i = 1'b0;
    endtask

    task automatic serve_rd(input bit spurious);
        int t = 0;
        while (!bus.rd_req_o && t < 20) begin @(negedge clk); t++; end
        chk("rd_req_seen", bus.rd_req_o, 1'b1);
        if (spurious) begin
            bus.ret_valid_i = 1'b1; bus.ret_last_i = 1'b1; bus.ret_data_i = 32'hBAD0BAD0;
            @(negedge clk);
            bus.ret_valid_i = 1'b0; bus.ret_last_i = 1'b0;
        end
        bus.rd_rdy_i = 1'b1;
        @(negedge clk);
        bus.rd_rdy_i = 1'b0;
    endtask

    task automatic send_beats(input logic [127:0] line, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.ret_valid_i = 1'b1;
            bus.ret_data_i  = line[i*32 +: 32];
            bus.ret_last_i  = (i == 3);
            @(negedge clk);
            bus.ret_valid_i = 1'b0;
            bus.ret_last_i  = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!miss_ready && t < 50) begin @(negedge clk); t++; end
        chk("return_to_idle", miss_ready, 1'b1);
        @(negedge clk);
    endtask

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] LD = 128'hCAFEF00D_01234567_89ABCDEF_5A5AA5A5;
    localparam logic [127:0] L6 = 128'h04040404_03030303_02020202_01010101;

    initial begin
        miss_valid = 0; miss_index = 0; miss_tag = 0; miss_offset = 0; miss_op = 0;
        miss_wstrb = 0; miss_wdata = 0; victim_way = 0; victim_line = 0;
        bus.wr_rdy_i = 0; bus.rd_rdy_i = 0; bus.ret_valid_i = 0; bus.ret_last_i = 0;
        bus.ret_data_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_bridge_reqs", {bus.wr_req_o, bus.rd_req_o, bus.wr_addr_o, bus.rd_addr_o}, '0);
        chk("rst_way_req", way_req, '0);
        chk("rst_way_w_data", way_w_data, '0);
        chk("rst_done", {done, done_rdata}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean load miss, invalid victim
        rd_q.push_back(32'hABCDE120);
        push_done(2'b10, 8'h12, {1'b1, 20'hABCDE, L1, 1'b0}, 32'h33333333, 4'h8, 6);
        issue(8'h12, 20'hABCDE, 4'h8, 1'b0, 4'h0, 32'h0, 1'b1, {2'b00, 20'h11111, {4{32'h55555555}}});
        serve_rd(1'b0);
        send_beats(L1, 4, 0);
        wait_idle();

        // Dirty victim with a 3-cycle writeback stall
        push_wr(32'h00F0F120, LD);
        rd_q.push_back(32'h12345120);
        push_done(2'b01, 8'h12, {1'b1, 20'h12345, LA, 1'b0}, 32'hA0A0A0A0, 4'h0, 10);
        issue(8'h12, 20'h12345, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, {1'b1, 1'b1, 20'h00F0F, LD});
        serve_wr(3);
        serve_rd(1'b0);
        send_beats(LA, 4, 0);
        wait_idle();

        // Store merge into word 1, low two bytes
        rd_q.push_back(32'h0BEEF340);
        push_done(2'b01, 8'h34, {1'b1, 20'h0BEEF, 128'h44444444_33333333_2222BEEF_11111111, 1'b1},
                  32'h2222BEEF, 4'h4, 6);
        issue(8'h34, 20'h0BEEF, 4'h4, 1'b1, 4'b0011, 32'hDEADBEEF, 1'b0, {2'b00, 20'h0, 128'h0});
        serve_rd(1'b0);
        send_beats(L1, 4, 0);
        wait_idle();

        // Bubbles between beats and a spurious beat while the fetch is pending
        rd_q.push_back(32'hABCDE120);
        push_done(2'b10, 8'h12, {1'b1, 20'hABCDE, L1, 1'b0}, 32'h33333333, 4'h8, -1);
        issue(8'h12, 20'hABCDE, 4'h8, 1'b0, 4'h0, 32'h0, 1'b1, {2'b00, 20'h22222, 128'h0});
        serve_rd(1'b1);
        send_beats(L1, 4, 2);
        wait_idle();

        // Reset after two beats: no way write, stray beats afterwards ignored
        rd_q.push_back(32'h77777560);
        issue(8'h56, 20'h77777, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, {2'b00, 20'h0, 128'h0});
        serve_rd(1'b0);
        send_beats(L1, 2, 0);
        rst_n = 1'b0;
        bus.ret_valid_i = 1'b1; bus.ret_data_i = 32'h99999999;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_miss_ready", miss_ready, 1'b1);
        rst_n = 1'b1;
        bus.ret_last_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.ret_valid_i = 1'b0; bus.ret_last_i = 1'b0;
        @(negedge clk);
        chk("postrst_miss_ready", miss_ready, 1'b1);
        chk("postrst_no_fetch", bus.rd_req_o, 1'b0);

        // Valid clean victim, store to word 3 upper bytes: no writeback expected
        rd_q.push_back(32'h135799A0);
        push_done(2'b10, 8'h9A, {1'b1, 20'h13579, 128'hFEDC0404_03030303_02020202_01010101, 1'b1},
                  32'hFEDC0404, 4'hC, 6);
        issue(8'h9A, 20'h13579, 4'hC, 1'b1, 4'b1100, 32'hFEDCBA98, 1'b1,
              {1'b0, 1'b1, 20'hFFFFF, {4{32'hFFFFFFFF}}});
        serve_rd(1'b0);
        send_beats(L6, 4, 0);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queues_drained", 150'(wr_q.size() + rd_q.size() + done_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
